// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: status/enable/vector/epc/cause registers, interrupt-pending
// synchronizers and the 64-bit cycle/instret counters, with one read port and one write port.
module trap_csr (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        set_cause_i,
  input  logic        ie_type_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        instret_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]  mie_q;  // {meie, mtie, msie}
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [2:0]  irq_sync1_q, irq_sync2_q;  // {external, timer, sw}

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  always_comb begin
    wr_mstatus   = csr_we_i && (csr_waddr_i == AddrMstatus);
    wr_mie       = csr_we_i && (csr_waddr_i == AddrMie);
    wr_mtvec     = csr_we_i && (csr_waddr_i == AddrMtvec);
    wr_mscratch  = csr_we_i && (csr_waddr_i == AddrMscratch);
    wr_mepc      = csr_we_i && (csr_waddr_i == AddrMepc);
    wr_mcause    = csr_we_i && (csr_waddr_i == AddrMcause);
    wr_mtval     = csr_we_i && (csr_waddr_i == AddrMtval);
    wr_mcycle    = csr_we_i && (csr_waddr_i == AddrMcycle);
    wr_mcycleh   = csr_we_i && (csr_waddr_i == AddrMcycleh);
    wr_minstret  = csr_we_i && (csr_waddr_i == AddrMinstret);
    wr_minstreth = csr_we_i && (csr_waddr_i == AddrMinstreth);
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      irq_sync1_q    <= '0;
      irq_sync2_q    <= '0;
    end else begin
      irq_sync1_q <= {irq_external_i, irq_timer_i, irq_sw_i};
      irq_sync2_q <= irq_sync1_q;

      // Trap-side updates take precedence over a software write to the same register.
      if (mstatus_ie_clear_i) begin
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mstatus_ie_set_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie_q  <= csr_wdata_i[3];
        mstatus_mpie_q <= csr_wdata_i[7];
      end

      if (wr_mie)      mie_q      <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
      if (wr_mtvec)    mtvec_q    <= {csr_wdata_i[31:2], 1'b0, csr_wdata_i[0]};
      if (wr_mscratch) mscratch_q <= csr_wdata_i;

      if (set_epc_i)    mepc_q <= {epc_i[31:2], 2'b00};
      else if (wr_mepc) mepc_q <= {csr_wdata_i[31:2], 2'b00};

      if (set_cause_i)    mcause_q <= {ie_type_i, 27'b0, trap_cause_i};
      else if (wr_mcause) mcause_q <= csr_wdata_i;

      if (set_mtval_i)   mtval_q <= mtval_i;
      else if (wr_mtval) mtval_q <= csr_wdata_i;

      if (wr_mcycle)       mcycle_q[31:0]  <= csr_wdata_i;
      else if (wr_mcycleh) mcycle_q[63:32] <= csr_wdata_i;
      else                 mcycle_q        <= mcycle_q + 64'd1;

      if (wr_minstret)       minstret_q[31:0]  <= csr_wdata_i;
      else if (wr_minstreth) minstret_q[63:32] <= csr_wdata_i;
      else if (instret_i)    minstret_q        <= minstret_q + 64'd1;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      AddrMstatus:   csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      AddrMisa:      csr_rdata_o = 32'h4000_0100;
      AddrMie:       csr_rdata_o = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      AddrMtvec:     csr_rdata_o = mtvec_q;
      AddrMscratch:  csr_rdata_o = mscratch_q;
      AddrMepc:      csr_rdata_o = mepc_q;
      AddrMcause:    csr_rdata_o = mcause_q;
      AddrMtval:     csr_rdata_o = mtval_q;
      AddrMip:       csr_rdata_o = {20'b0, irq_sync2_q[2], 3'b0, irq_sync2_q[1], 3'b0,
                                    irq_sync2_q[0], 3'b0};
      AddrMcycle:    csr_rdata_o = mcycle_q[31:0];
      AddrMinstret:  csr_rdata_o = minstret_q[31:0];
      AddrMcycleh:   csr_rdata_o = mcycle_q[63:32];
      AddrMinstreth: csr_rdata_o = minstret_q[63:32];
      AddrMhartid:   csr_rdata_o = '0;
      default:       csr_illegal_o = 1'b1;
    endcase
  end

  assign mstatus_ie_o   = mstatus_mie_q;
  assign mie_external_o = mie_q[2];
  assign mie_timer_o    = mie_q[1];
  assign mie_sw_o       = mie_q[0];
  assign mip_external_o = irq_sync2_q[2];
  assign mip_timer_o    = irq_sync2_q[1];
  assign mip_sw_o       = irq_sync2_q[0];
  assign mtvec_o        = mtvec_q;
  assign epc_o          = mepc_q;

endmodule

// File: tb/tb_trap_csr.sv
// Directed bench for trap_csr: one task per feature, each with inline hand-computed checks.
module tb_trap_csr;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_illegal, csr_we;
  logic        set_cause, ie_type, set_epc, set_mtval, ie_clear, ie_set;
  logic [3:0]  trap_cause;
  logic [31:0] epc, mtval;
  logic        irq_ext, irq_tmr, irq_sw, instret;
  logic        mstatus_ie, mie_ext, mie_tmr, mie_sw, mip_ext, mip_tmr, mip_sw;
  logic [31:0] mtvec_out, epc_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trap_csr dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .set_cause_i(set_cause), .ie_type_i(ie_type), .trap_cause_i(trap_cause),
    .set_epc_i(set_epc), .epc_i(epc), .set_mtval_i(set_mtval), .mtval_i(mtval),
    .mstatus_ie_clear_i(ie_clear), .mstatus_ie_set_i(ie_set),
    .irq_external_i(irq_ext), .irq_timer_i(irq_tmr), .irq_sw_i(irq_sw),
    .instret_i(instret),
    .mstatus_ie_o(mstatus_ie), .mie_external_o(mie_ext), .mie_timer_o(mie_tmr),
    .mie_sw_o(mie_sw), .mip_external_o(mip_ext), .mip_timer_o(mip_tmr), .mip_sw_o(mip_sw),
    .mtvec_o(mtvec_out), .epc_o(epc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_raddr = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'hDEADBEEF;
    set_epc = 1'b1; epc = 32'h44; ie_set = 1'b1; instret = 1'b1;
    tick(); tick();
    csr_we = 1'b0; set_epc = 1'b0; ie_set = 1'b0; instret = 1'b0;
    rd(12'h340); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL reset_mscratch got %h want %h", csr_rdata, 32'h0); end
    rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1800 || csr_illegal !== 1'b0) begin miscompares++;
      $display("FAIL reset_mstatus got %h/%b want 00001800/0", csr_rdata, csr_illegal); end
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL reset_mcycle got %h want 0", csr_rdata); end
    vectors++;
    if (epc_out !== 32'h0 || mtvec_out !== 32'h0 || mstatus_ie !== 1'b0 ||
        {mie_ext, mie_tmr, mie_sw, mip_ext, mip_tmr, mip_sw} !== 6'b0) begin miscompares++;
      $display("FAIL reset_outputs got epc=%h mtvec=%h ie=%b want 0", epc_out, mtvec_out,
               mstatus_ie); end
    n_rst = 1'b1;
    tick();
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'h1) begin miscompares++;
      $display("FAIL first_increment got %h want 1", csr_rdata); end
    rd(12'hB02); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL reset_minstret got %h want 0", csr_rdata); end
  endtask

  task automatic test_csr_rw();
    wr(12'h340, 32'hA5A51234);
    csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h1111;
    rd(12'h340); vectors++;
    if (csr_rdata !== 32'hA5A51234) begin miscompares++;
      $display("FAIL no_bypass got %h want a5a51234", csr_rdata); end
    tick(); csr_we = 1'b0;
    rd(12'h340); vectors++;
    if (csr_rdata !== 32'h1111) begin miscompares++;
      $display("FAIL mscratch_wr got %h want 00001111", csr_rdata); end
    wr(12'h301, 32'h0); rd(12'h301); vectors++;
    if (csr_rdata !== 32'h40000100) begin miscompares++;
      $display("FAIL misa got %h want 40000100", csr_rdata); end
    wr(12'hF14, 32'hFFFF); rd(12'hF14); vectors++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin miscompares++;
      $display("FAIL mhartid got %h/%b want 0/0", csr_rdata, csr_illegal); end
    wr(12'h304, 32'hFFFFFFFF); rd(12'h304); vectors++;
    if (csr_rdata !== 32'h888 || {mie_ext, mie_tmr, mie_sw} !== 3'b111) begin miscompares++;
      $display("FAIL mie_mask got %h/%b want 00000888/111", csr_rdata,
               {mie_ext, mie_tmr, mie_sw}); end
    wr(12'h304, 32'h80); rd(12'h304); vectors++;
    if (csr_rdata !== 32'h80 || {mie_ext, mie_tmr, mie_sw} !== 3'b010) begin miscompares++;
      $display("FAIL mie_timer got %h want 00000080", csr_rdata); end
    wr(12'h344, 32'hFFFFFFFF); rd(12'h344); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL mip_ro got %h want 0", csr_rdata); end
    wr(12'h305, 32'h00001003); rd(12'h305); vectors++;
    if (csr_rdata !== 32'h00001001 || mtvec_out !== 32'h00001001) begin miscompares++;
      $display("FAIL mtvec_mode got %h/%h want 00001001", csr_rdata, mtvec_out); end
    wr(12'h305, 32'hFFFFFFFE); rd(12'h305); vectors++;
    if (csr_rdata !== 32'hFFFFFFFC) begin miscompares++;
      $display("FAIL mtvec_mode2 got %h want fffffffc", csr_rdata); end
    wr(12'h341, 32'h12345677); rd(12'h341); vectors++;
    if (csr_rdata !== 32'h12345674 || epc_out !== 32'h12345674) begin miscompares++;
      $display("FAIL mepc_align got %h want 12345674", csr_rdata); end
    rd(12'h7C0); vectors++;
    if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL illegal got %b/%h want 1/0", csr_illegal, csr_rdata); end
  endtask

  task automatic test_trap_entry();
    wr(12'h300, 32'h8); rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1808 || mstatus_ie !== 1'b1) begin miscompares++;
      $display("FAIL mstatus_wr got %h want 00001808", csr_rdata); end
    set_epc = 1'b1; epc = 32'h80000106; set_cause = 1'b1; ie_type = 1'b1;
    trap_cause = 4'hB; ie_clear = 1'b1;
    tick();
    set_epc = 1'b0; set_cause = 1'b0; ie_clear = 1'b0;
    rd(12'h341); vectors++;
    if (csr_rdata !== 32'h80000104 || epc_out !== 32'h80000104) begin miscompares++;
      $display("FAIL trap_mepc got %h want 80000104", csr_rdata); end
    rd(12'h342); vectors++;
    if (csr_rdata !== 32'h8000000B) begin miscompares++;
      $display("FAIL trap_mcause got %h want 8000000b", csr_rdata); end
    rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1880 || mstatus_ie !== 1'b0) begin miscompares++;
      $display("FAIL trap_mstatus got %h want 00001880", csr_rdata); end
  endtask

  task automatic test_trap_return();
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1888 || mstatus_ie !== 1'b1) begin miscompares++;
      $display("FAIL mret_mstatus got %h want 00001888", csr_rdata); end
    ie_set = 1'b1; ie_clear = 1'b1; tick(); ie_set = 1'b0; ie_clear = 1'b0;
    rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1880) begin miscompares++;
      $display("FAIL clear_wins got %h want 00001880", csr_rdata); end
  endtask

  task automatic test_conflict();
    csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h100;
    set_epc = 1'b1; epc = 32'h200;
    tick(); csr_we = 1'b0; set_epc = 1'b0;
    rd(12'h341); vectors++;
    if (csr_rdata !== 32'h200) begin miscompares++;
      $display("FAIL conflict_mepc got %h want 00000200", csr_rdata); end
    csr_we = 1'b1; csr_waddr = 12'h343; csr_wdata = 32'h5678;
    set_mtval = 1'b1; mtval = 32'h1234;
    tick(); csr_we = 1'b0; set_mtval = 1'b0;
    rd(12'h343); vectors++;
    if (csr_rdata !== 32'h1234) begin miscompares++;
      $display("FAIL conflict_mtval got %h want 00001234", csr_rdata); end
    csr_we = 1'b1; csr_waddr = 12'h342; csr_wdata = 32'h7;
    set_cause = 1'b1; ie_type = 1'b0; trap_cause = 4'h3;
    tick(); csr_we = 1'b0; set_cause = 1'b0;
    rd(12'h342); vectors++;
    if (csr_rdata !== 32'h3) begin miscompares++;
      $display("FAIL conflict_mcause got %h want 00000003", csr_rdata); end
    // MIE=0, MPIE=1 here; clear gives MPIE=0 while the dropped write would set both
    csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = 32'h88; ie_clear = 1'b1;
    tick(); csr_we = 1'b0; ie_clear = 1'b0;
    rd(12'h300); vectors++;
    if (csr_rdata !== 32'h1800) begin miscompares++;
      $display("FAIL conflict_mstatus got %h want 00001800", csr_rdata); end
  endtask

  task automatic test_counters();
    wr(12'hB00, 32'hFFFFFFFF);
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'hFFFFFFFF) begin miscompares++;
      $display("FAIL mcycle_wr got %h want ffffffff", csr_rdata); end
    tick();
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL wrap_low got %h want 0", csr_rdata); end
    rd(12'hB80); vectors++;
    if (csr_rdata !== 32'h1) begin miscompares++;
      $display("FAIL wrap_high got %h want 1", csr_rdata); end
    wr(12'hB80, 32'h5);
    rd(12'hB80); vectors++;
    if (csr_rdata !== 32'h5) begin miscompares++;
      $display("FAIL mcycleh_wr got %h want 5", csr_rdata); end
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL mcycleh_wr_low got %h want 0", csr_rdata); end
    tick();
    rd(12'hB00); vectors++;
    if (csr_rdata !== 32'h1) begin miscompares++;
      $display("FAIL mcycle_resume got %h want 1", csr_rdata); end
  endtask

  task automatic test_minstret();
    instret = 1'b1; tick(); tick(); tick(); instret = 1'b0;
    rd(12'hB02); vectors++;
    if (csr_rdata !== 32'h3) begin miscompares++;
      $display("FAIL minstret_count got %h want 3", csr_rdata); end
    for (int i = 0; i < 10; i++) tick();
    rd(12'hB02); vectors++;
    if (csr_rdata !== 32'h3) begin miscompares++;
      $display("FAIL minstret_hold got %h want 3", csr_rdata); end
    instret = 1'b1;
    wr(12'hB02, 32'hFFFFFFFF);
    rd(12'hB02); vectors++;
    if (csr_rdata !== 32'hFFFFFFFF) begin miscompares++;
      $display("FAIL minstret_wr_suppress got %h want ffffffff", csr_rdata); end
    tick(); instret = 1'b0;
    rd(12'hB02); vectors++;
    if (csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL minstret_wrap_low got %h want 0", csr_rdata); end
    rd(12'hB82); vectors++;
    if (csr_rdata !== 32'h1) begin miscompares++;
      $display("FAIL minstret_wrap_high got %h want 1", csr_rdata); end
  endtask

  task automatic test_irq_sync();
    irq_tmr = 1'b1;
    tick();
    rd(12'h344); vectors++;
    if (mip_tmr !== 1'b0 || csr_rdata !== 32'h0) begin miscompares++;
      $display("FAIL irq_edge1 got %b/%h want 0/0", mip_tmr, csr_rdata); end
    tick();
    rd(12'h344); vectors++;
    if (mip_tmr !== 1'b1 || csr_rdata !== 32'h80) begin miscompares++;
      $display("FAIL irq_edge2 got %b/%h want 1/00000080", mip_tmr, csr_rdata); end
    irq_tmr = 1'b0; irq_ext = 1'b1; irq_sw = 1'b1;
    tick(); tick();
    rd(12'h344); vectors++;
    if (csr_rdata !== 32'h808 || {mip_ext, mip_tmr, mip_sw} !== 3'b101) begin miscompares++;
      $display("FAIL irq_ext_sw got %h/%b want 00000808/101", csr_rdata,
               {mip_ext, mip_tmr, mip_sw}); end
  endtask

  initial begin
    n_rst = 1'b0; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_we = 1'b0;
    set_cause = 1'b0; ie_type = 1'b0; trap_cause = '0; set_epc = 1'b0; epc = '0;
    set_mtval = 1'b0; mtval = '0; ie_clear = 1'b0; ie_set = 1'b0;
    irq_ext = 1'b0; irq_tmr = 1'b0; irq_sw = 1'b0; instret = 1'b0;
    #2;
    test_reset();
    test_csr_rw();
    test_trap_entry();
    test_trap_return();
    test_conflict();
    test_counters();
    test_minstret();
    test_irq_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
